// File: rtl/alu_exec_seq_pkg.sv
// Shared opcode/func constants, internal ALU op codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_exec_seq_pkg;

   // Instruction opcodes
   localparam int unsigned OPCODE_BNE   = 0;
   localparam int unsigned OPCODE_BEQ   = 1;
   localparam int unsigned OPCODE_BGZ   = 2;
   localparam int unsigned OPCODE_BLZ   = 3;
   localparam int unsigned OPCODE_ADI   = 4;
   localparam int unsigned OPCODE_ORI   = 5;
   localparam int unsigned OPCODE_RTYPE = 15;

   // R-type function codes
   localparam int unsigned FUNC_ADD = 0;
   localparam int unsigned FUNC_SUB = 1;
   localparam int unsigned FUNC_AND = 2;
   localparam int unsigned FUNC_ORR = 3;
   localparam int unsigned FUNC_NOT = 4;
   localparam int unsigned FUNC_TCP = 5;
   localparam int unsigned FUNC_SHL = 6;
   localparam int unsigned FUNC_SHR = 7;
   localparam int unsigned FUNC_MUL = 8;

   // Internal ALU operation after decode
   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_ORR = 4'd3,
      OP_NOT = 4'd4,
      OP_TCP = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_MUL = 4'd8,
      OP_BNE = 4'd9,
      OP_BEQ = 4'd10,
      OP_BGZ = 4'd11,
      OP_BLZ = 4'd12
   } alu_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_exec_seq_mul.sv
// Iterative shift-add multiplier, low WORD_W bits of a*b.
// Latency: fixed WORD_W cycles from start to o_done (o_done is combinational in the last cycle).
// Backpressure: none; caller must not restart while a product is in flight.
module alu_mul_iter #(
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_start,
   input  logic [WORD_W-1:0] i_a,
   input  logic [WORD_W-1:0] i_b,
   output logic              o_done,
   output logic [WORD_W-1:0] o_product
);
   localparam int CNT_W = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] r_mcand;
   logic [WORD_W-1:0] r_mplier;
   logic [WORD_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_count;
   logic [WORD_W-1:0] w_acc_next;

   // Partial-product add for the current multiplier bit
   always_comb begin
      w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   end

   // The final iteration's accumulator is handed out directly so the
   // caller can register it on the same edge that finishes the count.
   assign o_done    = (r_count == CNT_W'(1));
   assign o_product = w_acc_next;

   // Load on start, then one shift-add step per cycle until count hits 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
      end else if (i_start) begin
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
         r_count  <= CNT_W'(WORD_W);
      end else if (r_count != '0) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_exec_seq.sv
// Handshaked ALU execute stage: decode, single-cycle ops, registered result, iterative MUL.
// Latency: 1 cycle for single-cycle ops, WORD_W cycles for MUL.
// Backpressure: result holds while out_valid && !out_ready; in_ready low while busy or blocked.
module alu_exec_seq
   import alu_exec_seq_pkg::*;
#(
   parameter int WORD_W = 16,
   parameter int OPC_W  = 4,
   parameter int FUNC_W = 6,
   parameter int MUL_EN = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [FUNC_W-1:0] func_code,
   input  logic              alu_mode,
   input  logic [WORD_W-1:0] operand_a,
   input  logic [WORD_W-1:0] operand_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] result,
   output logic              branch_taken,
   output logic              overflow,
   output logic              busy
);
   localparam int MSB = WORD_W - 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_out_valid;
   logic [WORD_W-1:0] r_result;
   logic              r_branch;
   logic              r_ovf;

   alu_op_t           w_op;
   logic [WORD_W-1:0] w_b_eff;
   logic [WORD_W-1:0] w_sum;
   logic [WORD_W-1:0] w_res;
   logic              w_branch;
   logic              w_ovf;
   logic              w_accept;
   logic              w_is_mul;
   logic              w_mul_done;
   logic [WORD_W-1:0] w_mul_prod;

   // Decode opcode/func under the ALU-mode select
   always_comb begin
      w_op = OP_ADD;
      if (alu_mode) begin
         case (opcode)
            OPC_W'(OPCODE_RTYPE): begin
               case (func_code)
                  FUNC_W'(FUNC_SUB): w_op = OP_SUB;
                  FUNC_W'(FUNC_AND): w_op = OP_AND;
                  FUNC_W'(FUNC_ORR): w_op = OP_ORR;
                  FUNC_W'(FUNC_NOT): w_op = OP_NOT;
                  FUNC_W'(FUNC_TCP): w_op = OP_TCP;
                  FUNC_W'(FUNC_SHL): w_op = OP_SHL;
                  FUNC_W'(FUNC_SHR): w_op = OP_SHR;
                  FUNC_W'(FUNC_MUL): w_op = (MUL_EN != 0) ? OP_MUL : OP_ADD;
                  default:           w_op = OP_ADD;
               endcase
            end
            OPC_W'(OPCODE_ADI): w_op = OP_ADD;
            OPC_W'(OPCODE_ORI): w_op = OP_ORR;
            OPC_W'(OPCODE_BNE): w_op = OP_BNE;
            OPC_W'(OPCODE_BEQ): w_op = OP_BEQ;
            OPC_W'(OPCODE_BGZ): w_op = OP_BGZ;
            OPC_W'(OPCODE_BLZ): w_op = OP_BLZ;
            default:            w_op = OP_ADD;
         endcase
      end
   end

   // Single-cycle datapath; subtract reuses the adder with a negated b
   always_comb begin
      w_b_eff  = (w_op == OP_SUB) ? (~operand_b + WORD_W'(1)) : operand_b;
      w_sum    = operand_a + w_b_eff;
      w_ovf    = 1'b0;
      w_branch = 1'b0;
      w_res    = '0;
      case (w_op)
         OP_ADD, OP_SUB: begin
            w_res = w_sum;
            w_ovf = (operand_a[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != operand_a[MSB]);
         end
         OP_AND: w_res = operand_a & operand_b;
         OP_ORR: w_res = operand_a | operand_b;
         OP_NOT: w_res = ~operand_a;
         OP_TCP: w_res = '0 - operand_a;
         OP_SHL: w_res = operand_a << 1;
         OP_SHR: w_res = {operand_a[MSB], operand_a[MSB:1]};
         OP_BNE: w_branch = (operand_a != operand_b);
         OP_BEQ: w_branch = (operand_a == operand_b);
         OP_BGZ: w_branch = !operand_a[MSB] && (operand_a != '0);
         OP_BLZ: w_branch = operand_a[MSB];
         default: w_res = '0;
      endcase
   end

   // in_ready is forced low while reset is held so nothing is taken mid-reset
   assign in_ready = reset_n && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_is_mul = (w_op == OP_MUL);

   alu_mul_iter #(
      .WORD_W (WORD_W)
   ) u_mul (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_start   (w_accept && w_is_mul),
      .i_a       (operand_a),
      .i_b       (operand_b),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next state: leave IDLE only for an accepted multiply
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept && w_is_mul) w_state_nxt = ST_MUL;
         ST_MUL:  if (w_mul_done)           w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output register: load on accept or multiply completion, clear on drain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_branch    <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_accept && !w_is_mul) begin
         r_out_valid <= 1'b1;
         r_result    <= w_res;
         r_branch    <= w_branch;
         r_ovf       <= w_ovf;
      end else if (w_accept) begin
         r_out_valid <= 1'b0;
         r_branch    <= 1'b0;
         r_ovf       <= 1'b0;
      end else if ((r_state == ST_MUL) && w_mul_done) begin
         r_out_valid <= 1'b1;
         r_result    <= w_mul_prod;
         r_branch    <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid    = r_out_valid;
   assign result       = r_result;
   assign branch_taken = r_branch;
   assign overflow     = r_ovf;
   assign busy         = (r_state == ST_MUL);

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq with hand-computed expectations.
// Latency: checks 1-cycle ops and the fixed 16-cycle multiply.
// Backpressure: exercises out_ready stalls and drain+accept in the same cycle.
module tb_alu_exec_seq;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [5:0]  func_code;
   logic        alu_mode;
   logic [15:0] operand_a;
   logic [15:0] operand_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        branch_taken;
   logic        overflow;
   logic        busy;

   int total = 0;
   int bad   = 0;

   alu_exec_seq #(
      .WORD_W (16),
      .OPC_W  (4),
      .FUNC_W (6),
      .MUL_EN (1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .opcode       (opcode),
      .func_code    (func_code),
      .alu_mode     (alu_mode),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .branch_taken (branch_taken),
      .overflow     (overflow),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one op at the falling edge; it is taken on the next rising edge.
   // Returns #1 after that edge with in_valid already dropped.
   task automatic do_op(input logic mode, input logic [3:0] opc, input logic [5:0] fn,
                        input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      in_valid  = 1'b1;
      alu_mode  = mode;
      opcode    = opc;
      func_code = fn;
      operand_a = a;
      operand_b = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      alu_mode  = 1'b0;
      opcode    = '0;
      func_code = '0;
      operand_a = '0;
      operand_b = '0;

      // Reset state
      #12;
      chk("rst_outs", {out_valid, branch_taken, overflow, busy, in_ready}, 5'b00000);
      chk("rst_result", result, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);

      // Forced ADD under alu_mode=0, opcode BEQ
      do_op(1'b0, 4'd1, 6'd0, 16'h0010, 16'h0004);
      chk("mode0_valid", out_valid, 1'b1);
      chk("mode0_result", result, 16'h0014);
      chk("mode0_branch", branch_taken, 1'b0);

      // Signed overflow edges and arithmetic shift
      do_op(1'b1, 4'd15, 6'd0, 16'h7FFF, 16'h0001);
      chk("add_ovf", {overflow, result}, {1'b1, 16'h8000});
      do_op(1'b1, 4'd15, 6'd1, 16'h8000, 16'h0001);
      chk("sub_ovf", {overflow, result}, {1'b1, 16'h7FFF});
      do_op(1'b1, 4'd15, 6'd7, 16'h8002, 16'h0000);
      chk("shr", {overflow, result}, {1'b0, 16'hC001});
      do_op(1'b1, 4'd15, 6'd5, 16'h8000, 16'h0000);
      chk("tcp_minneg", {overflow, result}, {1'b0, 16'h8000});
      do_op(1'b1, 4'd4, 6'd0, 16'h1234, 16'hFFFF);
      chk("adi", {overflow, result}, {1'b0, 16'h1233});

      // Branches: result always 0
      do_op(1'b1, 4'd3, 6'd0, 16'hFFFF, 16'h0000);
      chk("blz", {branch_taken, result}, {1'b1, 16'h0000});
      do_op(1'b1, 4'd2, 6'd0, 16'h0000, 16'h0000);
      chk("bgz", {branch_taken, result}, {1'b0, 16'h0000});
      do_op(1'b1, 4'd0, 6'd0, 16'h0005, 16'h0005);
      chk("bne", {branch_taken, result}, {1'b0, 16'h0000});
      do_op(1'b1, 4'd1, 6'd0, 16'h0005, 16'h0005);
      chk("beq", {branch_taken, result}, {1'b1, 16'h0000});

      // Multiply: exactly 16 cycles, busy and in_ready held throughout
      do_op(1'b1, 4'd15, 6'd8, 16'h0123, 16'h0045);
      chk("mul1_start", {out_valid, busy, in_ready}, 3'b010);
      for (int k = 1; k < 16; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("mul1_wait%0d", k), {out_valid, busy, in_ready}, 3'b010);
      end
      @(posedge clk);
      #1;
      chk("mul1_done", {out_valid, busy}, 2'b10);
      chk("mul1_result", result, 16'h4E6F);

      do_op(1'b1, 4'd15, 6'd8, 16'hFFFF, 16'hFFFF);
      repeat (16) @(posedge clk);
      #1;
      chk("mul2_done", {out_valid, busy, result}, {2'b10, 16'h0001});

      // Reset in the middle of a multiply
      do_op(1'b1, 4'd15, 6'd8, 16'h0003, 16'h0005);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_outs", {out_valid, branch_taken, overflow, busy, in_ready}, 5'b00000);
      chk("midrst_result", result, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("midrst_quiet%0d", k), {out_valid, busy}, 2'b00);
      end

      // Backpressure: hold ORI result, then drain and accept together
      out_ready = 1'b0;
      do_op(1'b1, 4'd5, 6'd0, 16'h00F0, 16'h000F);
      chk("ori_result", {out_valid, result}, {1'b1, 16'h00FF});
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d", k), {out_valid, in_ready, result}, {2'b10, 16'h00FF});
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      alu_mode  = 1'b1;
      opcode    = 4'd15;
      func_code = 6'd0;
      operand_a = 16'h0002;
      operand_b = 16'h0003;
      #1;
      chk("drain_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("drain_accept", {out_valid, result}, {1'b1, 16'h0005});
      @(posedge clk);
      #1;
      chk("drain_empty", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
